// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with rename tag table, commit bypass and branch checkpoints
module rename_reg_file #(
   parameter int ROB_WIDTH  = 3,
   parameter int REG_WIDTH  = 5,
   parameter int NUM_RP     = 4,
   parameter int NUM_CMT    = 2,
   parameter int CKPT_WIDTH = 2
) (
   input  logic                              clk_in,
   input  logic                              rst_n_in,
   input  logic                              rdy_in,
   input  logic                              flush_in,
   input  logic [NUM_RP*REG_WIDTH-1:0]       rp_idx,
   output logic [NUM_RP*(ROB_WIDTH+1)-1:0]   rp_q,
   output logic [NUM_RP*32-1:0]              rp_v,
   input  logic                              alloc_en,
   input  logic [REG_WIDTH-1:0]              alloc_rd,
   input  logic [ROB_WIDTH-1:0]              alloc_tag,
   input  logic [NUM_CMT-1:0]                cmt_en,
   input  logic [NUM_CMT*REG_WIDTH-1:0]      cmt_rd,
   input  logic [NUM_CMT*ROB_WIDTH-1:0]      cmt_tag,
   input  logic [NUM_CMT*32-1:0]             cmt_data,
   input  logic                              ckpt_save_en,
   input  logic [CKPT_WIDTH-1:0]             ckpt_save_id,
   input  logic                              ckpt_restore_en,
   input  logic [CKPT_WIDTH-1:0]             ckpt_restore_id,
   input  logic                              ckpt_free_en,
   input  logic [CKPT_WIDTH-1:0]             ckpt_free_id,
   output logic [(1<<CKPT_WIDTH)-1:0]        ckpt_valid
);
   localparam int TW       = ROB_WIDTH + 1;
   localparam int REG_SIZE = 1 << REG_WIDTH;
   localparam int NUM_CKPT = 1 << CKPT_WIDTH;
   localparam logic [TW-1:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};
   typedef logic [REG_SIZE-1:0][TW-1:0] tbl_t;

   logic [31:0]         regs_q [REG_SIZE];
   logic [31:0]         regs_d [REG_SIZE];
   tbl_t                tag_q, tag_d;
   tbl_t                snap_q [NUM_CKPT];
   tbl_t                snap_d [NUM_CKPT];
   logic [NUM_CKPT-1:0] valid_q, valid_d;
   logic                keep_mode;

   // A tag table with this cycle's commit clears applied: an entry clears only if it still names the retiring RoB slot.
   function automatic tbl_t clr(input tbl_t t);
      tbl_t r;
      r = t;
      for (int k = 0; k < NUM_CMT; k++)
         if (cmt_en[k] && cmt_rd[k*REG_WIDTH+:REG_WIDTH] != '0 &&
             r[cmt_rd[k*REG_WIDTH+:REG_WIDTH]] == {1'b0, cmt_tag[k*ROB_WIDTH+:ROB_WIDTH]})
            r[cmt_rd[k*REG_WIDTH+:REG_WIDTH]] = NON_DEP;
      return r;
   endfunction

   // One read port: {tag, value}, with same-cycle commit bypass where the youngest matching port wins.
   function automatic logic [TW+31:0] rd_port(input logic [REG_WIDTH-1:0] idx);
      logic [TW-1:0] t;
      logic          byp;
      logic [31:0]   bd;
      t   = tag_q[idx];
      byp = 1'b0;
      bd  = '0;
      for (int k = 0; k < NUM_CMT; k++)
         if (cmt_en[k] && cmt_rd[k*REG_WIDTH+:REG_WIDTH] == idx &&
             t == {1'b0, cmt_tag[k*ROB_WIDTH+:ROB_WIDTH]}) begin
            byp = 1'b1;
            bd  = cmt_data[k*32+:32];
         end
      if (idx == '0) return {NON_DEP, 32'd0};
      if (flush_in || byp || t == NON_DEP) return {NON_DEP, byp ? bd : regs_q[idx]};
      return {t, 32'd0};
   endfunction

   for (genvar g = 0; g < NUM_RP; g++) begin : g_rp
      assign {rp_q[g*TW+:TW], rp_v[g*32+:32]} = rd_port(rp_idx[g*REG_WIDTH+:REG_WIDTH]);
   end

   assign ckpt_valid = valid_q;
   assign keep_mode  = !flush_in && !ckpt_restore_en;

   // Next state: commits always, then flush > restore > normal rename/save; free applies unless flushing.
   always_comb begin
      regs_d = regs_q;
      for (int k = 0; k < NUM_CMT; k++)
         if (cmt_en[k] && cmt_rd[k*REG_WIDTH+:REG_WIDTH] != '0)
            regs_d[cmt_rd[k*REG_WIDTH+:REG_WIDTH]] = cmt_data[k*32+:32];
      tag_d = flush_in ? {REG_SIZE{NON_DEP}} :
              (ckpt_restore_en && valid_q[ckpt_restore_id]) ? clr(snap_q[ckpt_restore_id]) : clr(tag_q);
      if (keep_mode && alloc_en && alloc_rd != '0) tag_d[alloc_rd] = {1'b0, alloc_tag};
      valid_d = valid_q;
      if (ckpt_free_en) valid_d[ckpt_free_id] = 1'b0;
      if (keep_mode && ckpt_save_en) valid_d[ckpt_save_id] = 1'b1;
      if (flush_in) valid_d = '0;
      for (int i = 0; i < NUM_CKPT; i++)
         snap_d[i] = (keep_mode && ckpt_save_en && ckpt_save_id == CKPT_WIDTH'(i)) ? tag_d : clr(snap_q[i]);
   end

   // State registers; rdy_in low freezes everything.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < REG_SIZE; i++) regs_q[i] <= '0;
         for (int i = 0; i < NUM_CKPT; i++) snap_q[i] <= {REG_SIZE{NON_DEP}};
         tag_q   <= {REG_SIZE{NON_DEP}};
         valid_q <= '0;
      end else if (rdy_in) begin
         regs_q  <= regs_d;
         snap_q  <= snap_d;
         tag_q   <= tag_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: tb/tb_rename_reg_file.sv
// tb_rename_reg_file: directed scoreboard bench for the rename register file
module tb_rename_reg_file;
   localparam int RW = 5;
   localparam int TW = 4;
   localparam logic [3:0] ND = 4'd8;

   logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
   logic [19:0] rp_idx = '0;
   logic [15:0] rp_q;
   logic [127:0] rp_v;
   logic        alloc_en = 1'b0;
   logic [4:0]  alloc_rd = '0;
   logic [2:0]  alloc_tag = '0;
   logic [1:0]  cmt_en = '0;
   logic [9:0]  cmt_rd = '0;
   logic [5:0]  cmt_tag = '0;
   logic [63:0] cmt_data = '0;
   logic        ckpt_save_en = 1'b0, ckpt_restore_en = 1'b0, ckpt_free_en = 1'b0;
   logic [1:0]  ckpt_save_id = '0, ckpt_restore_id = '0, ckpt_free_id = '0;
   logic [3:0]  ckpt_valid;

   always #5 clk_in = ~clk_in;

   rename_reg_file dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .rp_idx(rp_idx), .rp_q(rp_q), .rp_v(rp_v),
      .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
      .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
      .ckpt_save_en(ckpt_save_en), .ckpt_save_id(ckpt_save_id),
      .ckpt_restore_en(ckpt_restore_en), .ckpt_restore_id(ckpt_restore_id),
      .ckpt_free_en(ckpt_free_en), .ckpt_free_id(ckpt_free_id),
      .ckpt_valid(ckpt_valid)
   );

   int n_chk = 0, n_pass = 0;
   string       sb_tag [$];
   int          sb_port [$];
   logic [3:0]  sb_q [$];
   logic [31:0] sb_v [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // drive a read port and queue the value it must return
   task automatic exp_rd(input string tag, input int p, input logic [4:0] idx, input logic [3:0] q, input logic [31:0] v);
      rp_idx[p*RW+:RW] = idx;
      sb_tag.push_back(tag);
      sb_port.push_back(p);
      sb_q.push_back(q);
      sb_v.push_back(v);
   endtask

   task automatic sample();
      string t;
      int p;
      logic [3:0] q;
      logic [31:0] v;
      @(negedge clk_in);
      while (sb_tag.size() > 0) begin
         t = sb_tag.pop_front();
         p = sb_port.pop_front();
         q = sb_q.pop_front();
         v = sb_v.pop_front();
         check({t, ".q"}, 32'(rp_q[p*TW+:TW]), 32'(q));
         check({t, ".v"}, rp_v[p*32+:32], v);
      end
   endtask

   task automatic idle();
      rdy_in = 1'b1; flush_in = 1'b0; alloc_en = 1'b0; cmt_en = '0;
      ckpt_save_en = 1'b0; ckpt_restore_en = 1'b0; ckpt_free_en = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      idle();
   endtask

   task automatic alloc(input logic [4:0] rd, input logic [2:0] tg);
      alloc_en = 1'b1; alloc_rd = rd; alloc_tag = tg;
   endtask

   task automatic cmt(input int k, input logic [4:0] rd, input logic [2:0] tg, input logic [31:0] d);
      cmt_en[k] = 1'b1; cmt_rd[k*5+:5] = rd; cmt_tag[k*3+:3] = tg; cmt_data[k*32+:32] = d;
   endtask

   initial begin
      exp_rd("rst_x5", 0, 5, ND, 0);
      exp_rd("rst_x0", 1, 0, ND, 0);
      sample();
      check("rst_valid", 32'(ckpt_valid), 0);
      rst_n_in = 1'b1;
      tick();
      cmt(0, 5, 3, 32'h1234);
      tick();
      exp_rd("t1_x5", 0, 5, ND, 32'h1234);
      sample();
      alloc(7, 2);
      tick();
      exp_rd("t2_pend", 2, 7, 4'd2, 0);
      sample();
      tick();
      cmt(1, 7, 2, 32'hAA);
      exp_rd("t2_byp", 2, 7, ND, 32'hAA);
      sample();
      tick();
      exp_rd("t2_after", 2, 7, ND, 32'hAA);
      sample();
      alloc(4, 1);
      tick();
      alloc(4, 5);
      tick();
      cmt(0, 4, 1, 9);
      exp_rd("t3_stale", 3, 4, 4'd5, 0);
      sample();
      tick();
      rdy_in = 1'b0; flush_in = 1'b1;
      exp_rd("t3_flushrd", 3, 4, ND, 9);
      sample();
      tick();
      exp_rd("t3_held", 3, 4, 4'd5, 0);
      sample();
      cmt(0, 3, 0, 1);
      cmt(1, 3, 1, 2);
      tick();
      exp_rd("t4_x3", 0, 3, ND, 2);
      sample();
      alloc(1, 0);
      ckpt_save_en = 1'b1; ckpt_save_id = 2'd1;
      tick();
      check("t5_valid", 32'(ckpt_valid), 32'h2);
      alloc(1, 6);
      tick();
      exp_rd("t5_x1_new", 1, 1, 4'd6, 0);
      sample();
      cmt(0, 1, 0, 32'h55);
      tick();
      exp_rd("t5_x1_old_cmt", 1, 1, 4'd6, 0);
      sample();
      ckpt_restore_en = 1'b1; ckpt_restore_id = 2'd1;
      tick();
      exp_rd("t5_x1_rest", 1, 1, ND, 32'h55);
      exp_rd("t5_x4_rest", 2, 4, 4'd5, 0);
      sample();
      check("t5_valid_kept", 32'(ckpt_valid), 32'h2);
      ckpt_restore_en = 1'b1; ckpt_restore_id = 2'd2;
      alloc(9, 3);
      tick();
      exp_rd("inv_rest_x9", 0, 9, ND, 0);
      exp_rd("inv_rest_x4", 1, 4, 4'd5, 0);
      sample();
      alloc(2, 4);
      ckpt_save_en = 1'b1; ckpt_save_id = 2'd0;
      tick();
      check("t6_valid", 32'(ckpt_valid), 32'h3);
      flush_in = 1'b1;
      exp_rd("t6_flush_x2", 0, 2, ND, 0);
      sample();
      tick();
      check("t6_valid_clr", 32'(ckpt_valid), 0);
      exp_rd("t6_x2", 0, 2, ND, 0);
      exp_rd("t6_x4", 1, 4, ND, 9);
      sample();
      rdy_in = 1'b0;
      cmt(0, 6, 0, 32'h77);
      ckpt_save_en = 1'b1; ckpt_save_id = 2'd3;
      tick();
      check("hold_valid", 32'(ckpt_valid), 0);
      exp_rd("hold_x6", 2, 6, ND, 0);
      sample();
      ckpt_save_en = 1'b1; ckpt_save_id = 2'd2;
      ckpt_free_en = 1'b1; ckpt_free_id = 2'd2;
      tick();
      check("save_free", 32'(ckpt_valid), 32'h4);
      ckpt_free_en = 1'b1; ckpt_free_id = 2'd2;
      tick();
      check("free", 32'(ckpt_valid), 0);
      alloc(8, 1);
      cmt(0, 10, 0, 5);
      tick();
      exp_rd("pre_rst_x8", 0, 8, 4'd1, 0);
      exp_rd("pre_rst_x10", 1, 10, ND, 5);
      sample();
      #1 rst_n_in = 1'b0;
      exp_rd("mid_rst_x8", 0, 8, ND, 0);
      exp_rd("mid_rst_x10", 1, 10, ND, 0);
      sample();
      rst_n_in = 1'b1;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
